// File: rtl/btn_event_fifo.sv
// Button event queue: four press pulses coalesce into pending flags, drained L>R>U>D
// into a first-word-fall-through FIFO. Define BTN_EVT_DROP_CNT_EN to add o_drop_cnt.
module btn_event_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter logic [7:0]  CODE_L = 8'h4C,
    parameter logic [7:0]  CODE_R = 8'h52,
    parameter logic [7:0]  CODE_U = 8'h55,
    parameter logic [7:0]  CODE_D = 8'h44
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_l,
    input  logic       i_btn_r,
    input  logic       i_btn_u,
    input  logic       i_btn_d,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_full
`ifdef BTN_EVT_DROP_CNT_EN
    ,
    output logic [7:0] o_drop_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [3:0]    pulse;
    logic [3:0]    pend;
    logic [3:0]    grant;
    logic [3:0]    clr;
    logic [3:0]    drop;
    logic [7:0]    wr_code;
    logic          wr;
    logic          pop;
    logic          full;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    mem [DEPTH];

    assign pulse = {i_btn_d, i_btn_u, i_btn_r, i_btn_l};

    always_comb begin
        grant   = '0;
        wr_code = '0;
        if (pend[0]) begin
            grant   = 4'b0001;
            wr_code = CODE_L;
        end else if (pend[1]) begin
            grant   = 4'b0010;
            wr_code = CODE_R;
        end else if (pend[2]) begin
            grant   = 4'b0100;
            wr_code = CODE_U;
        end else if (pend[3]) begin
            grant   = 4'b1000;
            wr_code = CODE_D;
        end
    end

    assign full    = (count == CW'(DEPTH));
    assign o_valid = (count != '0);
    assign o_full  = full;
    assign pop     = o_valid & i_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts a write.
    assign wr      = (|pend) & (~full | pop);
    assign clr     = wr ? grant : '0;
    assign drop    = pulse & pend & ~clr;
    assign o_data  = o_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            pend <= (pend & ~clr) | pulse;
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= wr_code;
    end

`ifdef BTN_EVT_DROP_CNT_EN
    logic [2:0] n_drop;
    logic [8:0] drop_sum;

    assign n_drop   = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
    assign drop_sum = {1'b0, o_drop_cnt} + {6'b0, n_drop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            o_drop_cnt <= '0;
        else
            o_drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
`endif

endmodule

// File: tb/tb_btn_event_fifo.sv
// Directed self-checking bench for btn_event_fifo (DEPTH=4, default codes).
module tb_btn_event_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_btn_l = 1'b0;
    logic       i_btn_r = 1'b0;
    logic       i_btn_u = 1'b0;
    logic       i_btn_d = 1'b0;
    logic       i_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_full;
`ifdef BTN_EVT_DROP_CNT_EN
    logic [7:0] o_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    btn_event_fifo #(.DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_btn_l (i_btn_l),
        .i_btn_r (i_btn_r),
        .i_btn_u (i_btn_u),
        .i_btn_d (i_btn_d),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_full  (o_full)
`ifdef BTN_EVT_DROP_CNT_EN
        ,
        .o_drop_cnt (o_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {i_btn_l, i_btn_r, i_btn_u, i_btn_d} = '0;
        i_ready = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // All four pressed together, then four writes fill the queue with 4C,52,55,44.
    task automatic fill_queue();
        {i_btn_l, i_btn_r, i_btn_u, i_btn_d} = 4'b1111;
        tick();
        {i_btn_l, i_btn_r, i_btn_u, i_btn_d} = '0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++;
        if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", o_full); end
        checks++;
        if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", o_data); end
`ifdef BTN_EVT_DROP_CNT_EN
        checks++;
        if (o_drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop: got %0d expected 0", o_drop_cnt); end
`endif
    endtask

    task automatic test_single_press();
        do_reset();
        i_ready = 1'b1;
        i_btn_l = 1'b1;
        tick();
        i_btn_l = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL single_c1_valid: got %b expected 0", o_valid); end
        tick();
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL single_c2_valid: got %b expected 1", o_valid); end
        checks++;
        if (o_data !== 8'h4C) begin errors++; $display("FAIL single_c2_data: got %h expected 4c", o_data); end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL single_c3_valid: got %b expected 0", o_valid); end
        checks++;
        if (o_data !== 8'h00) begin errors++; $display("FAIL single_c3_data: got %h expected 00", o_data); end
        i_ready = 1'b0;
    endtask

    task automatic test_fill_priority();
        logic [7:0] exp [4] = '{8'h4C, 8'h52, 8'h55, 8'h44};
        do_reset();
        {i_btn_l, i_btn_r, i_btn_u, i_btn_d} = 4'b1111;
        tick();
        {i_btn_l, i_btn_r, i_btn_u, i_btn_d} = '0;
        repeat (3) tick();
        checks++;
        if (o_full !== 1'b0) begin errors++; $display("FAIL fill_3_full: got %b expected 0", o_full); end
        tick();
        checks++;
        if (o_full !== 1'b1) begin errors++; $display("FAIL fill_4_full: got %b expected 1", o_full); end
        checks++;
        if (o_data !== 8'h4C) begin errors++; $display("FAIL fill_hold_data: got %h expected 4c", o_data); end
        tick();
        checks++;
        if (o_data !== 8'h4C) begin errors++; $display("FAIL fill_stable_data: got %h expected 4c", o_data); end
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp[i]) begin
                errors++;
                $display("FAIL fill_pop%0d: got valid=%b data=%h expected valid=1 data=%h", i, o_valid, o_data, exp[i]);
            end
            tick();
        end
        checks++;
        if (o_valid !== 1'b0 || o_full !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty: got valid=%b full=%b expected 0 0", o_valid, o_full);
        end
        i_ready = 1'b0;
    endtask

    task automatic test_full_drop();
        logic [7:0] exp [5] = '{8'h4C, 8'h52, 8'h55, 8'h44, 8'h55};
        do_reset();
        fill_queue();
        i_btn_u = 1'b1;
        tick();
        i_btn_u = 1'b0;
        tick();
        tick();
        i_btn_u = 1'b1;
        tick();
        i_btn_u = 1'b0;
        checks++;
        if (o_full !== 1'b1 || o_data !== 8'h4C) begin
            errors++;
            $display("FAIL drop_full_state: got full=%b data=%h expected 1 4c", o_full, o_data);
        end
`ifdef BTN_EVT_DROP_CNT_EN
        checks++;
        if (o_drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt_one: got %0d expected 1", o_drop_cnt); end
`endif
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp[i]) begin
                errors++;
                $display("FAIL drop_pop%0d: got valid=%b data=%h expected valid=1 data=%h", i, o_valid, o_data, exp[i]);
            end
            tick();
        end
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL drop_empty: got %b expected 0", o_valid); end
        i_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp [4] = '{8'h52, 8'h55, 8'h44, 8'h52};
        do_reset();
        fill_queue();
        i_btn_r = 1'b1;
        tick();
        i_btn_r = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        checks++;
        if (o_full !== 1'b1 || o_data !== 8'h52) begin
            errors++;
            $display("FAIL pushpop_full: got full=%b data=%h expected 1 52", o_full, o_data);
        end
        tick();
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp[i]) begin
                errors++;
                $display("FAIL pushpop_pop%0d: got valid=%b data=%h expected valid=1 data=%h", i, o_valid, o_data, exp[i]);
            end
            tick();
        end
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL pushpop_flag_clear: got valid %b expected 0", o_valid); end
        i_ready = 1'b0;
    endtask

    task automatic test_set_wins();
        do_reset();
        i_btn_l = 1'b1;
        tick();
        tick();
        i_btn_l = 1'b0;
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h4C || o_full !== 1'b0) begin
            errors++;
            $display("FAIL setwins_state: got valid=%b data=%h full=%b expected 1 4c 0", o_valid, o_data, o_full);
        end
`ifdef BTN_EVT_DROP_CNT_EN
        checks++;
        if (o_drop_cnt !== 8'd0) begin errors++; $display("FAIL setwins_drop: got %0d expected 0", o_drop_cnt); end
`endif
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h4C) begin
            errors++;
            $display("FAIL setwins_second: got valid=%b data=%h expected 1 4c", o_valid, o_data);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL setwins_empty: got %b expected 0", o_valid); end
        i_ready = 1'b0;
    endtask

    task automatic test_coalesce();
        do_reset();
        i_btn_l = 1'b1;
        i_btn_r = 1'b1;
        tick();
        i_btn_l = 1'b0;
        tick();
        i_btn_r = 1'b0;
        tick();
        tick();
`ifdef BTN_EVT_DROP_CNT_EN
        checks++;
        if (o_drop_cnt !== 8'd1) begin errors++; $display("FAIL coalesce_drop: got %0d expected 1", o_drop_cnt); end
`endif
        i_ready = 1'b1;
        checks++;
        if (o_data !== 8'h4C) begin errors++; $display("FAIL coalesce_first: got %h expected 4c", o_data); end
        tick();
        checks++;
        if (o_data !== 8'h52) begin errors++; $display("FAIL coalesce_second: got %h expected 52", o_data); end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL coalesce_empty: got %b expected 0", o_valid); end
        i_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        {i_btn_l, i_btn_r, i_btn_u} = 3'b111;
        tick();
        {i_btn_l, i_btn_r, i_btn_u} = '0;
        repeat (3) tick();
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b expected 1", o_valid); end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 8'h00 || o_full !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: got valid=%b data=%h full=%b expected 0 00 0", o_valid, o_data, o_full);
        end
        #1;
        rst = 1'b1;
        i_btn_d = 1'b1;
        tick();
        i_btn_d = 1'b0;
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h44) begin
            errors++;
            $display("FAIL areset_first_d: got valid=%b data=%h expected 1 44", o_valid, o_data);
        end
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL areset_only_d: got %b expected 0", o_valid); end
        i_ready = 1'b0;
    endtask

`ifdef BTN_EVT_DROP_CNT_EN
    task automatic test_drop_count();
        do_reset();
        fill_queue();
        {i_btn_l, i_btn_r, i_btn_u, i_btn_d} = 4'b1111;
        tick();
        tick();
        {i_btn_l, i_btn_r, i_btn_u, i_btn_d} = '0;
        checks++;
        if (o_drop_cnt !== 8'd4) begin errors++; $display("FAIL drop_four: got %0d expected 4", o_drop_cnt); end
        do_reset();
        fill_queue();
        i_btn_l = 1'b1;
        repeat (301) tick();
        i_btn_l = 1'b0;
        checks++;
        if (o_drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d expected 255", o_drop_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_press();
        test_fill_priority();
        test_full_drop();
        test_full_push_pop();
        test_set_wins();
        test_coalesce();
        test_async_reset();
`ifdef BTN_EVT_DROP_CNT_EN
        test_drop_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
